refill_mem_arbiter: RTL and testbench
=====================================

// Module: refill_mem_arbiter
// PURPOSE
//  Shares the single backing-memory port between IF-stage I-cache line refills and MA-stage D-cache
//  line refills / word writes. Sequences each transaction as a word burst, returns fill data to the
//  owning cache, and raises o_busy for the stall unit. D side has priority; I side has anti-starvation aging.
// PARAMETERS
//  ADDR_W   30  word-address width (memory is word-addressed)
//  DATA_W   32  word width
//  LINE_W   4   words per cache line (power of 2, >=2); LOG_L = clog2(LINE_W)
// PORTS
//  Clk           in  1       clock, all state on rising edge
//  Rst           in  1       synchronous reset, active high
//  i_i_req       in  1       I-cache miss: line fill request, held high until o_i_done
//  i_i_addr      in  ADDR_W  I miss word address (low LOG_L bits ignored)
//  i_d_req       in  1       D-cache request, held high until o_d_done
//  i_d_we        in  1       1 = single-word write, 0 = line fill
//  i_d_addr      in  ADDR_W  D word address (full address used for writes)
//  i_d_wdata     in  DATA_W  D write data
//  o_fill_data   out DATA_W  refill word (shared bus to both caches)
//  o_fill_idx    out LOG_L   word index within line of o_fill_data
//  o_i_fill_vld  out 1       o_fill_data valid for I-cache
//  o_d_fill_vld  out 1       o_fill_data valid for D-cache
//  o_i_done      out 1       1-cycle pulse: I transaction complete
//  o_d_done      out 1       1-cycle pulse: D transaction complete
//  o_busy        out 1       any transaction in progress (state != IDLE)
//  o_mem_req     out 1       memory request, held until i_mem_ack
//  o_mem_we      out 1       memory write enable
//  o_mem_addr    out ADDR_W  memory word address
//  o_mem_wdata   out DATA_W  memory write data
//  i_mem_ack     in  1       memory accepted current request (read: data follows on rvalid)
//  i_mem_rvalid  in  1       read data valid
//  i_mem_rdata   in  DATA_W  read data
// BEHAVIOUR
//  - Reset (sync, any state): state=IDLE, cnt=0, starve=0; every output 0. i_mem_rvalid arriving after
//    reset for a pre-reset request is dropped (IDLE ignores rvalid).
//  - FSM: IDLE, RD_REQ, RD_WAIT, WR_REQ. Owner register own in {I,D} latched on leaving IDLE.
//  - IDLE arbitration (per cycle): D req & I req & starve -> I; else D req -> D; else I req -> I.
//    Grant to D while i_i_req=1 sets starve; grant to I clears starve.
//  - A requester's req is ignored in IDLE during the cycle right after its done pulse (req drop slack).
//  - D write: IDLE -> WR_REQ; o_mem_req=1, we=1, addr=i_d_addr, wdata=i_d_wdata (latched at grant);
//    on i_mem_ack: o_d_done pulse next cycle, -> IDLE.
//  - Line fill: IDLE -> RD_REQ with base={addr[ADDR_W-1:LOG_L],0}, cnt=0. RD_REQ: o_mem_req=1, we=0,
//    addr=base|cnt; on i_mem_ack -> RD_WAIT (req drops). RD_WAIT: on i_mem_rvalid register rdata into
//    o_fill_data, o_fill_idx=cnt, pulse owner's fill_vld next cycle; if cnt==LINE_W-1 pulse owner's done
//    in that same cycle and -> IDLE, else cnt+1 -> RD_REQ. One word in flight at a time.
//  - Latency: req sampled in IDLE cycle t -> o_mem_req high cycle t+1. Zero-wait memory (ack same cycle,
//    rvalid next): line fill = 2*LINE_W+1 cycles from grant edge to done.
//  - Outputs registered; o_mem_* stable while o_mem_req=1 and ack=0. cnt wraps only via reset to 0 on
//    new grant. i_mem_ack outside RD_REQ/WR_REQ, rvalid outside RD_WAIT: ignored.
//  - Requester dropping req mid-transaction: burst still completes, done still pulses (no abort).
// STRUCTURE
//  - Shared package arb_pkg: state encodings (IDLE/RD_REQ/RD_WAIT/WR_REQ), owner IDs (OWN_I, OWN_D).
//  - Sub-module refill_word_counter: LOG_L-bit counter, clear/inc, last-word flag. Rest inline.
// TESTING
//  1. I fill only, addr=0x103, LINE_W=4, zero-wait mem -> reads 0x100..0x103 in order, 4 i_fill_vld, idx 0..3, o_i_done with idx 3.
//  2. I and D fill requested same cycle, starve=0 -> D served first, starve=1, then I served; starve=0 after.
//  3. Back-to-back D requests while I pending -> order D, I, D (aging prevents second D preempting).
//  4. D write addr=0x2A, data=0xDEADBEEF, ack delayed 3 cycles -> mem signals stable 4 cycles, one write, o_d_done once.
//  5. Reset asserted in RD_WAIT of word 2, rvalid arrives next cycle -> all outputs 0, no fill_vld, IDLE.
//  6. Requester keeps req high the cycle after done -> no re-grant that cycle; re-grant following cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the refill memory arbiter.
//   state_e : burst sequencer states
//   owner_e : which cache owns the transaction in flight
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage : arb_pkg

// File: rtl/refill_word_counter.sv
// Word-within-line counter for refill bursts.
//   Clk, Rst : clock, synchronous active-high reset
//   clr      : restart at word 0 (new grant); wins over inc
//   inc      : advance to the next word
//   cnt      : current word index
//   last     : cnt is the final word of the line
module refill_word_counter #(
  parameter  int LINE_W = 4,
  localparam int LOG_L  = $clog2(LINE_W)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             clr,
  input  logic             inc,
  output logic [LOG_L-1:0] cnt,
  output logic             last
);

  // NOTE: Rst is tested inside the clocked block, so reset only acts on a rising edge.
  always_ff @(posedge Clk) begin
    if (Rst || clr) cnt <= '0;
    else if (inc)   cnt <= cnt + 1'b1;
  end

  assign last = (cnt == LOG_L'(LINE_W - 1));

endmodule : refill_word_counter

// File: rtl/refill_mem_arbiter.sv
// Arbitrates the single backing-memory port between I-cache line fills and
// D-cache line fills / single-word writes. Each fill is a burst of one-word
// reads with one word in flight; fill words are returned on a shared bus.
//   Clk, Rst                  : clock, synchronous active-high reset
//   i_i_req/i_i_addr          : I-cache line fill request (held until o_i_done)
//   i_d_req/i_d_we/i_d_addr/i_d_wdata : D-cache fill (we=0) or word write (we=1)
//   o_fill_data/o_fill_idx    : registered refill word and its index in the line
//   o_i_fill_vld/o_d_fill_vld : fill word valid for the owning cache
//   o_i_done/o_d_done         : one-cycle completion pulses
//   o_busy                    : a transaction is in progress (stall unit)
//   o_mem_*                   : memory request, held until i_mem_ack
//   i_mem_ack/i_mem_rvalid/i_mem_rdata : memory handshake and read data
module refill_mem_arbiter
  import arb_pkg::*;
#(
  parameter  int ADDR_W = 30,
  parameter  int DATA_W = 32,
  parameter  int LINE_W = 4,
  localparam int LOG_L  = $clog2(LINE_W)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_i_req,
  input  logic [ADDR_W-1:0] i_i_addr,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic [DATA_W-1:0] o_fill_data,
  output logic [LOG_L-1:0]  o_fill_idx,
  output logic              o_i_fill_vld,
  output logic              o_d_fill_vld,
  output logic              o_i_done,
  output logic              o_d_done,
  output logic              o_busy,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  // Clears the word-index bits to form the line base address.
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(LINE_W - 1);

  state_e state_q, state_d;
  owner_e own_q, own_d;
  logic   starve_q, starve_d;

  logic             cnt_clr, cnt_inc, cnt_last;
  logic [LOG_L-1:0] cnt;

  logic i_live, d_live, grant_i, grant_d;

  logic              mem_req_d, mem_we_d, busy_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, fill_data_d;
  logic [LOG_L-1:0]  fill_idx_d;
  logic              i_vld_d, d_vld_d, i_done_d, d_done_d;

  refill_word_counter #(.LINE_W(LINE_W)) u_cnt (
    .Clk  (Clk),
    .Rst  (Rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .last (cnt_last)
  );

  // A requester still holds req while its done pulse is out; that stale
  // request must not start a second transaction.
  assign i_live  = i_i_req && !o_i_done;
  assign d_live  = i_d_req && !o_d_done;
  assign grant_i = (state_q == IDLE) && i_live && (!d_live || starve_q);
  assign grant_d = (state_q == IDLE) && d_live && !grant_i;

  // Next-state logic
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path infers a latch.
    state_d  = state_q;
    own_d    = own_q;
    starve_d = starve_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          own_d    = OWN_I;
          starve_d = 1'b0;
          cnt_clr  = 1'b1;
          state_d  = RD_REQ;
        end else if (grant_d) begin
          own_d    = OWN_D;
          starve_d = i_live;  // I was passed over: it wins the next tie
          cnt_clr  = 1'b1;
          state_d  = i_d_we ? WR_REQ : RD_REQ;
        end
      end
      RD_REQ:  if (i_mem_ack) state_d = RD_WAIT;
      RD_WAIT: begin
        if (i_mem_rvalid) begin
          if (cnt_last) begin
            state_d = IDLE;
          end else begin
            cnt_inc = 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      WR_REQ:  if (i_mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    mem_req_d   = (state_d == RD_REQ) || (state_d == WR_REQ);
    mem_we_d    = (state_d == WR_REQ);
    busy_d      = (state_d != IDLE);
    mem_addr_d  = o_mem_addr;
    mem_wdata_d = o_mem_wdata;
    fill_data_d = o_fill_data;
    fill_idx_d  = o_fill_idx;
    i_vld_d     = 1'b0;
    d_vld_d     = 1'b0;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;

    if (grant_d && i_d_we) begin
      mem_addr_d  = i_d_addr;
      mem_wdata_d = i_d_wdata;
    end else if (grant_i) begin
      mem_addr_d = i_i_addr & BASE_MASK;
    end else if (grant_d) begin
      mem_addr_d = i_d_addr & BASE_MASK;
    end else if (cnt_inc) begin
      // Base is line aligned, so the next word only touches the index bits.
      mem_addr_d[LOG_L-1:0] = cnt + 1'b1;
    end

    if ((state_q == RD_WAIT) && i_mem_rvalid) begin
      fill_data_d = i_mem_rdata;
      fill_idx_d  = cnt;
      i_vld_d     = (own_q == OWN_I);
      d_vld_d     = (own_q == OWN_D);
      i_done_d    = cnt_last && (own_q == OWN_I);
      d_done_d    = cnt_last && (own_q == OWN_D);
    end

    if ((state_q == WR_REQ) && i_mem_ack) d_done_d = 1'b1;
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (Rst) begin
      state_q      <= IDLE;
      own_q        <= OWN_I;
      starve_q     <= 1'b0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_fill_data  <= '0;
      o_fill_idx   <= '0;
      o_i_fill_vld <= 1'b0;
      o_d_fill_vld <= 1'b0;
      o_i_done     <= 1'b0;
      o_d_done     <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state_q      <= state_d;
      own_q        <= own_d;
      starve_q     <= starve_d;
      o_mem_req    <= mem_req_d;
      o_mem_we     <= mem_we_d;
      o_mem_addr   <= mem_addr_d;
      o_mem_wdata  <= mem_wdata_d;
      o_fill_data  <= fill_data_d;
      o_fill_idx   <= fill_idx_d;
      o_i_fill_vld <= i_vld_d;
      o_d_fill_vld <= d_vld_d;
      o_i_done     <= i_done_d;
      o_d_done     <= d_done_d;
      o_busy       <= busy_d;
    end
  end

endmodule : refill_mem_arbiter

// File: tb/tb_refill_mem_arbiter.sv
// Directed bench for refill_mem_arbiter with a behavioural memory
// (configurable ack and rvalid delays) and logs of reads, writes and fills.
module tb_refill_mem_arbiter;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        i_i_req = 1'b0;
  logic [29:0] i_i_addr = '0;
  logic        i_d_req = 1'b0;
  logic        i_d_we = 1'b0;
  logic [29:0] i_d_addr = '0;
  logic [31:0] i_d_wdata = '0;
  logic [31:0] o_fill_data;
  logic [1:0]  o_fill_idx;
  logic        o_i_fill_vld, o_d_fill_vld, o_i_done, o_d_done, o_busy;
  logic        o_mem_req, o_mem_we;
  logic [29:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack = 1'b0;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  refill_mem_arbiter dut (
    .Clk(Clk), .Rst(Rst),
    .i_i_req(i_i_req), .i_i_addr(i_i_addr),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .o_fill_data(o_fill_data), .o_fill_idx(o_fill_idx),
    .o_i_fill_vld(o_i_fill_vld), .o_d_fill_vld(o_d_fill_vld),
    .o_i_done(o_i_done), .o_d_done(o_d_done), .o_busy(o_busy),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] word_of(input logic [29:0] a);
    return 32'hA500_0000 ^ {2'b00, a};
  endfunction

  // ---------------- memory model and monitors ----------------
  typedef struct {
    bit          iv;
    bit          dv;
    logic [1:0]  idx;
    logic [31:0] data;
  } fill_t;

  logic [29:0] rd_log[$];
  fill_t       fill_log[$];
  int          wr_count = 0, i_done_cnt = 0, d_done_cnt = 0;
  logic [29:0] wr_addr_seen;
  logic [31:0] wr_data_seen;
  int          ack_delay = 0, rv_delay = 0;
  int          wait_cnt = 0, rv_cnt = 0;
  bit          pend = 1'b0;
  logic [29:0] pend_addr;

  always @(negedge Clk) begin
    i_mem_rvalid = 1'b0;
    if (pend) begin
      if (rv_cnt == rv_delay) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = word_of(pend_addr);
        pend         = 1'b0;
      end else begin
        rv_cnt++;
      end
    end
    i_mem_ack = 1'b0;
    if (o_mem_req) begin
      if (wait_cnt == ack_delay) begin
        i_mem_ack = 1'b1;
        wait_cnt  = 0;
        if (o_mem_we) begin
          wr_count++;
          wr_addr_seen = o_mem_addr;
          wr_data_seen = o_mem_wdata;
        end else begin
          rd_log.push_back(o_mem_addr);
          pend      = 1'b1;
          rv_cnt    = 0;
          pend_addr = o_mem_addr;
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  always @(negedge Clk) begin
    if (o_i_fill_vld || o_d_fill_vld)
      fill_log.push_back('{iv: o_i_fill_vld, dv: o_d_fill_vld, idx: o_fill_idx, data: o_fill_data});
    if (o_i_done) i_done_cnt++;
    if (o_d_done) d_done_cnt++;
  end

  // Waits for a done pulse; n is the number of falling edges consumed.
  task automatic wait_done(input bit d_side, input int budget, output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!(d_side ? o_d_done : o_i_done) && n < budget);
    checks++;
    if (!(d_side ? o_d_done : o_i_done)) begin
      errors++;
      $display("FAIL done_timeout: side=%0d saw no done pulse in %0d cycles, required one", d_side, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if ({o_fill_data, o_fill_idx, o_i_fill_vld, o_d_fill_vld, o_i_done, o_d_done, o_busy,
         o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b mem_req=%b addr=%h, required all outputs 0",
               o_busy, o_mem_req, o_mem_addr);
    end
    Rst = 1'b0;
    @(negedge Clk);
    checks++;
    if (o_busy !== 1'b0 || o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b mem_req=%b, required 0 0", o_busy, o_mem_req);
    end
  endtask

  task automatic test_i_fill();
    int n, base_done;
    rd_log.delete(); fill_log.delete();
    base_done = i_done_cnt;
    i_i_addr = 30'h103;
    i_i_req  = 1'b1;
    @(negedge Clk);
    checks++;
    if ({o_mem_req, o_mem_we, o_mem_addr, o_busy} !== {1'b1, 1'b0, 30'h100, 1'b1}) begin
      errors++;
      $display("FAIL ifill_first_req: got req=%b we=%b addr=%h busy=%b, required 1 0 100 1",
               o_mem_req, o_mem_we, o_mem_addr, o_busy);
    end
    wait_done(1'b0, 40, n);
    checks++;
    if (n + 1 != 9) begin
      errors++;
      $display("FAIL ifill_latency: got %0d cycles, required 9", n + 1);
    end
    checks++;
    if ({o_i_fill_vld, o_fill_idx, o_fill_data} !== {1'b1, 2'd3, word_of(30'h103)}) begin
      errors++;
      $display("FAIL ifill_done_word: got vld=%b idx=%0d data=%h, required 1 3 %h",
               o_i_fill_vld, o_fill_idx, o_fill_data, word_of(30'h103));
    end
    i_i_req = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (rd_log.size() != 4 || fill_log.size() != 4) begin
      errors++;
      $display("FAIL ifill_counts: got %0d reads %0d fills, required 4 4", rd_log.size(), fill_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rd_log[k] !== 30'h100 + 30'(k) ||
            {fill_log[k].iv, fill_log[k].dv, fill_log[k].idx, fill_log[k].data}
              !== {1'b1, 1'b0, 2'(k), word_of(30'h100 + 30'(k))}) begin
          errors++;
          $display("FAIL ifill_word%0d: got addr=%h iv=%b dv=%b idx=%0d data=%h, required addr=%h iv=1 dv=0 idx=%0d",
                   k, rd_log[k], fill_log[k].iv, fill_log[k].dv, fill_log[k].idx, fill_log[k].data,
                   30'h100 + 30'(k), k);
        end
      end
    end
    checks++;
    if (i_done_cnt - base_done != 1) begin
      errors++;
      $display("FAIL ifill_done_count: got %0d, required 1", i_done_cnt - base_done);
    end
  endtask

  task automatic test_d_priority();
    int n;
    logic [29:0] exp_rd[8];
    rd_log.delete(); fill_log.delete();
    i_i_addr = 30'h200; i_i_req = 1'b1;
    i_d_addr = 30'h305; i_d_we = 1'b0; i_d_req = 1'b1;
    @(negedge Clk);
    checks++;
    if ({o_mem_addr, dut.starve_q} !== {30'h304, 1'b1}) begin
      errors++;
      $display("FAIL prio_d_first: got addr=%h starve=%b, required 304 1", o_mem_addr, dut.starve_q);
    end
    wait_done(1'b1, 40, n);
    i_d_req = 1'b0;
    @(negedge Clk);
    checks++;
    if ({o_mem_req, o_mem_addr, dut.starve_q} !== {1'b1, 30'h200, 1'b0}) begin
      errors++;
      $display("FAIL prio_i_second: got req=%b addr=%h starve=%b, required 1 200 0",
               o_mem_req, o_mem_addr, dut.starve_q);
    end
    wait_done(1'b0, 40, n);
    i_i_req = 1'b0;
    repeat (3) @(negedge Clk);
    for (int k = 0; k < 4; k++) begin
      exp_rd[k]     = 30'h304 + 30'(k);
      exp_rd[k + 4] = 30'h200 + 30'(k);
    end
    checks++;
    if (rd_log.size() != 8) begin
      errors++;
      $display("FAIL prio_read_count: got %0d, required 8", rd_log.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (rd_log[k] !== exp_rd[k] || fill_log[k].dv !== (k < 4)) begin
          errors++;
          $display("FAIL prio_order%0d: got addr=%h dv=%b, required addr=%h dv=%b",
                   k, rd_log[k], fill_log[k].dv, exp_rd[k], k < 4);
        end
      end
    end
    checks++;
    if (dut.starve_q !== 1'b0) begin
      errors++;
      $display("FAIL prio_starve_after: got %b, required 0", dut.starve_q);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [29:0] exp_base[3];
    exp_base = '{30'h400, 30'h500, 30'h608};
    rd_log.delete(); fill_log.delete();
    i_i_addr = 30'h500; i_i_req = 1'b1;
    i_d_addr = 30'h400; i_d_we = 1'b0; i_d_req = 1'b1;
    wait_done(1'b1, 40, n);
    i_d_addr = 30'h60A;   // second D request follows immediately
    @(negedge Clk);
    checks++;
    if (o_mem_addr !== 30'h500) begin
      errors++;
      $display("FAIL b2b_i_not_preempted: got addr=%h, required 500", o_mem_addr);
    end
    wait_done(1'b0, 40, n);
    i_i_req = 1'b0;
    wait_done(1'b1, 40, n);
    i_d_req = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (rd_log.size() != 12) begin
      errors++;
      $display("FAIL b2b_read_count: got %0d, required 12", rd_log.size());
    end else begin
      for (int t = 0; t < 3; t++) begin
        checks++;
        if (rd_log[4*t] !== exp_base[t] || rd_log[4*t+3] !== exp_base[t] + 30'd3) begin
          errors++;
          $display("FAIL b2b_order%0d: got first=%h last=%h, required %h %h",
                   t, rd_log[4*t], rd_log[4*t+3], exp_base[t], exp_base[t] + 30'd3);
        end
      end
    end
  endtask

  task automatic test_d_write();
    int base_wr, base_done;
    base_wr   = wr_count;
    base_done = d_done_cnt;
    ack_delay = 3;
    i_d_addr = 30'h2A; i_d_wdata = 32'hDEADBEEF; i_d_we = 1'b1; i_d_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      checks++;
      if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata} !== {1'b1, 1'b1, 30'h2A, 32'hDEADBEEF}) begin
        errors++;
        $display("FAIL wr_stable_c%0d: got req=%b we=%b addr=%h data=%h, required 1 1 2a deadbeef",
                 c, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata);
      end
    end
    @(negedge Clk);
    checks++;
    if ({o_d_done, o_mem_req, o_busy} !== 3'b100) begin
      errors++;
      $display("FAIL wr_done: got done=%b req=%b busy=%b, required 1 0 0", o_d_done, o_mem_req, o_busy);
    end
    i_d_req = 1'b0; i_d_we = 1'b0;
    ack_delay = 0;
    @(negedge Clk);
    checks++;
    if (o_d_done !== 1'b0) begin
      errors++;
      $display("FAIL wr_done_pulse: got done=%b a cycle later, required 0", o_d_done);
    end
    repeat (3) @(negedge Clk);
    checks++;
    if (wr_count - base_wr != 1 || d_done_cnt - base_done != 1 ||
        wr_addr_seen !== 30'h2A || wr_data_seen !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_once: got writes=%0d dones=%0d addr=%h data=%h, required 1 1 2a deadbeef",
               wr_count - base_wr, d_done_cnt - base_done, wr_addr_seen, wr_data_seen);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n, base_done;
    rd_log.delete(); fill_log.delete();
    base_done = i_done_cnt;
    rv_delay = 1;
    i_i_addr = 30'h700; i_i_req = 1'b1;
    n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
    end while (rd_log.size() < 3 && n < 60);
    checks++;
    if (rd_log.size() != 3) begin
      errors++;
      $display("FAIL rst_reach_word2: got %0d reads, required 3", rd_log.size());
    end
    @(negedge Clk);            // word 2 is in RD_WAIT, its rvalid is one cycle out
    Rst = 1'b1; i_i_req = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    checks++;
    if ({o_fill_data, o_fill_idx, o_i_fill_vld, o_d_fill_vld, o_i_done, o_d_done, o_busy,
         o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got busy=%b req=%b addr=%h vld=%b, required all 0",
               o_busy, o_mem_req, o_mem_addr, o_i_fill_vld);
    end
    repeat (3) @(negedge Clk);
    rv_delay = 0;
    checks++;
    if (o_busy !== 1'b0 || o_mem_req !== 1'b0 || fill_log.size() != 2 || i_done_cnt != base_done) begin
      errors++;
      $display("FAIL rst_late_rvalid: got busy=%b req=%b fills=%0d dones=%0d, required 0 0 2 0",
               o_busy, o_mem_req, fill_log.size(), i_done_cnt - base_done);
    end
  endtask

  task automatic test_req_slack();
    int n;
    i_i_addr = 30'h800; i_i_req = 1'b1;
    wait_done(1'b0, 40, n);
    @(negedge Clk);            // req still high during the done cycle
    checks++;
    if (o_mem_req !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL slack_no_regrant: got req=%b busy=%b, required 0 0", o_mem_req, o_busy);
    end
    @(negedge Clk);
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 30'h800) begin
      errors++;
      $display("FAIL slack_regrant: got req=%b addr=%h, required 1 800", o_mem_req, o_mem_addr);
    end
    wait_done(1'b0, 40, n);
    i_i_req = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_i_fill();
    test_d_priority();
    test_back_to_back();
    test_d_write();
    test_reset_mid_burst();
    test_req_slack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_refill_mem_arbiter
